// File: rtl/window_gen.sv
// rtl/window_gen.sv - 3x3 raster window generator with two line buffers and done_i handshake.
// Optional frame counter output frame_cnt_o is enabled by defining WINDOW_GEN_FRAME_CNT_EN.
module window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic        clk_i_w,
    input  logic        rst_i_w,
    input  logic [7:0]  pix_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic [7:0]  data_o_0,
    output logic [7:0]  data_o_1,
    output logic [7:0]  data_o_2,
    output logic [7:0]  data_o_3,
    output logic [7:0]  data_o_4,
    output logic [7:0]  data_o_5,
    output logic [7:0]  data_o_6,
    output logic [7:0]  data_o_7,
    output logic [7:0]  data_o_8,
    output logic        en_o,
    input  logic        done_i,
`ifdef WINDOW_GEN_FRAME_CNT_EN
    output logic [15:0] frame_cnt_o,
`endif
    output logic        frame_done_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    logic [7:0]    win [3][3];
    logic          accept;
    logic [7:0]    lb1_rd;
    logic [7:0]    lb2_rd;

    assign pix_ready_o = ~en_o;
    assign accept      = pix_valid_i & ~en_o;
    assign lb1_rd      = lb1[col];
    assign lb2_rd      = lb2[col];

    // Line buffers carry no reset; stale rows are masked by the row>=2 gate.
    always_ff @(posedge clk_i_w) begin
        if (accept) begin
            lb2[col] <= lb1_rd;
            lb1[col] <= pix_i;
        end
    end

    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            col          <= '0;
            row          <= '0;
            en_o         <= 1'b0;
            frame_done_o <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            frame_done_o <= 1'b0;
            if (en_o && done_i) begin
                en_o <= 1'b0;
            end
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= pix_i;
                if (row >= ROW_TWO && col >= COL_TWO) begin
                    en_o <= 1'b1;
                end
                if (row == ROW_LAST && col == COL_LAST) begin
                    frame_done_o <= 1'b1;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

`ifdef WINDOW_GEN_FRAME_CNT_EN
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            frame_cnt_o <= '0;
        end else if (frame_done_o) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
`endif

    assign data_o_0 = win[0][0];
    assign data_o_1 = win[0][1];
    assign data_o_2 = win[0][2];
    assign data_o_3 = win[1][0];
    assign data_o_4 = win[1][1];
    assign data_o_5 = win[1][2];
    assign data_o_6 = win[2][0];
    assign data_o_7 = win[2][1];
    assign data_o_8 = win[2][2];
endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - directed scoreboard bench for window_gen at IMG_W=IMG_H=4.
module tb_window_gen;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix;
    logic        valid;
    logic        ready;
    logic        done;
    logic        en;
    logic        fdone;
    logic [7:0]  d0, d1, d2, d3, d4, d5, d6, d7, d8;
`ifdef WINDOW_GEN_FRAME_CNT_EN
    logic [15:0] fcnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          fd_count = 0;
    logic [71:0] exp_q [$];
    logic [7:0]  img [W*H];
    logic [71:0] win_now;

    assign win_now = {d0, d1, d2, d3, d4, d5, d6, d7, d8};

    always #5 clk = ~clk;

    window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk_i_w(clk), .rst_i_w(rst), .pix_i(pix), .pix_valid_i(valid),
        .pix_ready_o(ready),
        .data_o_0(d0), .data_o_1(d1), .data_o_2(d2), .data_o_3(d3), .data_o_4(d4),
        .data_o_5(d5), .data_o_6(d6), .data_o_7(d7), .data_o_8(d8),
        .en_o(en), .done_i(done),
`ifdef WINDOW_GEN_FRAME_CNT_EN
        .frame_cnt_o(fcnt),
`endif
        .frame_done_o(fdone)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[71-8*(3*i+j) -: 8] = img[(r-2+i)*W + (c-2+j)];
            end
        end
        return w;
    endfunction

    // Downstream 1-2-1 Gaussian stage fed from the window outputs.
    function automatic int gauss(input logic [71:0] w);
        int wt [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        for (int i = 0; i < 9; i++) begin
            s += wt[i] * int'(w[71-8*i -: 8]);
        end
        return s / 16;
    endfunction

    task automatic run_frame(input int n, input int hold, input bit stray_done, input bit check_gauss);
        int seen = 0;
        int expected = 0;
        for (int k = 0; k < n; k++) begin
            int r = k / W;
            int c = k % W;
            bit mk = (r >= 2) && (c >= 2);
            logic [71:0] e = '0;
            if (mk) begin
                exp_q.push_back(model_win(r, c));
                expected++;
            end
            pix   = img[k];
            valid = 1'b1;
            done  = stray_done;
            chk("ready_before_accept", 80'(ready), 80'(1));
            step();
            done = 1'b0;
            if (k + 1 < n) pix = img[k+1];
            else valid = 1'b0;
            chk("en_after_accept", 80'(en), 80'(mk));
            chk("frame_done", 80'(fdone), 80'(k == W*H-1));
            if (fdone === 1'b1) fd_count++;
            if (en === 1'b1) begin
                seen++;
                if (mk) begin
                    e = exp_q.pop_front();
                    chk("window", 80'(win_now), 80'(e));
                    if (check_gauss && seen == 1) chk("gauss_first", 80'(gauss(win_now)), 80'(6));
                end
                for (int i = 0; i < hold; i++) begin
                    step();
                    chk("hold", {6'b0, en, ready, win_now}, {6'b0, 1'b1, 1'b0, e});
                end
                done = 1'b1;
                step();
                done = 1'b0;
                chk("release", 80'({en, ready, fdone}), 80'(3'b010));
            end
        end
        valid = 1'b0;
        chk("window_count", 80'(seen), 80'(expected));
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; done = 1'b0; pix = '0;
        step();
        step();
        chk("reset_state", {7'b0, en, fdone, win_now}, 80'(0));
        #2 rst = 1'b0;
        step();
        chk("ready_after_reset", 80'({ready, en}), 80'(2'b10));

        for (int k = 0; k < W*H; k++) img[k] = 8'(k + 1);
        run_frame(W*H, 3, 1'b0, 1'b1);
        run_frame(W*H, 40, 1'b0, 1'b0);
        run_frame(W*H, 3, 1'b1, 1'b0);

        // Window pending, then reset asserted between clock edges.
        run_frame(10, 3, 1'b0, 1'b0);
        pix = img[10]; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("en_before_async_reset", 80'(en), 80'(1));
        #1 rst = 1'b1;
        #1 chk("async_reset", {7'b0, en, ready, win_now}, {7'b0, 1'b0, 1'b1, 72'(0)});
        #1 rst = 1'b0;
        step();
        run_frame(W*H, 3, 1'b0, 1'b0);

        run_frame(6, 3, 1'b0, 1'b0);
        pulse_reset();
        run_frame(W*H, 3, 1'b0, 1'b0);

        for (int k = 0; k < W*H; k++) img[k] = 8'd200;
        pulse_reset();
        fd_count = 0;
        run_frame(W*H, 1, 1'b0, 1'b0);
        run_frame(W*H, 1, 1'b0, 1'b0);
        step();
        chk("frame_done_pulses", 80'(fd_count), 80'(2));
`ifdef WINDOW_GEN_FRAME_CNT_EN
        chk("frame_cnt", 80'(fcnt), 80'(2));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
